yakirouter_sched: RTL and testbench

- Packet scheduler and crossbar controller for the 2x4 YakiRouter.
- Accepts packet headers from the two input channels and arbitrates round-robin per output channel.
- Holds each grant for the full packet length.
- Drives the mux-select and valid controls of the 2x4 datapath, plus per-input busy and error indications.

---
 rtl/yakirouter_pkg.sv | 12 +
 rtl/yakirouter_rr_arb2.sv | 18 +
 rtl/yakirouter_sched.sv | 81 ++++++++
 tb/tb_yakirouter_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/yakirouter_pkg.sv
// yakirouter_pkg: shared sizes and types for the 2x4 YakiRouter scheduler
package yakirouter_pkg;
  localparam int NUM_IN = 2;
  localparam int NUM_OUT = 4;
  localparam int DST_W = 2;
  localparam int HDR_LEN_W = 6;
  typedef enum logic {IDLE, ACTIVE} out_state_t;
  typedef struct packed {
    logic [DST_W-1:0] dst;
    logic [HDR_LEN_W-1:0] len;
  } hdr_t;
endpackage

// File: rtl/yakirouter_rr_arb2.sv
// yakirouter_rr_arb2: two-requester round-robin arbiter, priority flips away from each winner
module yakirouter_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       vld,
  output logic       win
);
  logic prio;
  always_comb begin
    vld = |req;
    win = req[1] & (~req[0] | prio);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= 1'b0;
    else if (upd) prio <= ~win;
endmodule

// File: rtl/yakirouter_sched.sv
// yakirouter_sched: per-output packet scheduler and crossbar control for the 2x4 YakiRouter
module yakirouter_sched
  import yakirouter_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic [NUM_IN-1:0]                 i_hdr_vld,
  input  logic [NUM_IN-1:0][DST_W-1:0]      i_hdr_dst,
  input  logic [NUM_IN-1:0][LEN_W-1:0]      i_hdr_len,
  input  logic [NUM_IN-1:0]                 i_beat_vld,
  output logic [NUM_IN-1:0]                 o_hdr_ack,
  output logic [NUM_IN-1:0]                 o_in_busy,
  output logic [NUM_OUT-1:0]                o_out_en,
  output logic [NUM_OUT-1:0]                o_out_src,
  output logic                              o_error
);
  out_state_t state [NUM_OUT];
  logic [LEN_W-1:0] rem [NUM_OUT];
  logic [NUM_IN-1:0] elig, zreq, grant_in, clr_in;
  logic [NUM_OUT-1:0][NUM_IN-1:0] req;
  logic [NUM_OUT-1:0] gvld, gwin, done;
  always_comb begin
    elig = i_hdr_vld & ~o_in_busy & ~o_hdr_ack;
    zreq = '0;
    req = '0;
    o_out_en = '0;
    done = '0;
    clr_in = '0;
    for (int i = 0; i < NUM_IN; i++)
      zreq[i] = elig[i] && i_hdr_len[i] == '0 && state[i_hdr_dst[i]] == IDLE;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++)
        req[o][i] = elig[i] && i_hdr_dst[i] == DST_W'(o) && i_hdr_len[i] != '0 && state[o] == IDLE;
      o_out_en[o] = state[o] == ACTIVE && i_beat_vld[o_out_src[o]];
      done[o] = o_out_en[o] && rem[o] == LEN_W'(1);
      clr_in[o_out_src[o]] = clr_in[o_out_src[o]] | done[o];
    end
  end
  always_comb begin
    grant_in = '0;
    for (int o = 0; o < NUM_OUT; o++)
      grant_in[gwin[o]] = grant_in[gwin[o]] | gvld[o];
  end
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_arb
    yakirouter_rr_arb2 u_arb (
      .clk  (i_clk),
      .rst_n(i_rstn),
      .req  (req[g]),
      .upd  (gvld[g]),
      .vld  (gvld[g]),
      .win  (gwin[g])
    );
  end
  // a beat on a non-busy input is dropped and flagged alongside zero-length headers
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      o_hdr_ack <= '0;
      o_in_busy <= '0;
      o_out_src <= '0;
      o_error <= 1'b0;
      for (int o = 0; o < NUM_OUT; o++) begin
        state[o] <= IDLE;
        rem[o] <= '0;
      end
    end else begin
      o_hdr_ack <= grant_in | zreq;
      o_in_busy <= (o_in_busy | grant_in) & ~clr_in;
      o_error <= |zreq || |(i_beat_vld & ~o_in_busy);
      for (int o = 0; o < NUM_OUT; o++)
        if (gvld[o]) begin
          state[o] <= ACTIVE;
          rem[o] <= i_hdr_len[gwin[o]];
          o_out_src[o] <= gwin[o];
        end else if (o_out_en[o]) begin
          rem[o] <= rem[o] - 1'b1;
          state[o] <= done[o] ? IDLE : ACTIVE;
        end
    end
endmodule

// File: tb/tb_yakirouter_sched.sv
// tb_yakirouter_sched: directed vectors with hand-computed expectations for yakirouter_sched
module tb_yakirouter_sched;
  import yakirouter_pkg::*;
  localparam int LEN_W = 6;
  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  logic [NUM_IN-1:0] i_hdr_vld = '0;
  logic [NUM_IN-1:0] i_beat_vld = '0;
  logic [NUM_IN-1:0][DST_W-1:0] i_hdr_dst = '0;
  logic [NUM_IN-1:0][LEN_W-1:0] i_hdr_len = '0;
  logic [NUM_IN-1:0] o_hdr_ack, o_in_busy;
  logic [NUM_OUT-1:0] o_out_en, o_out_src;
  logic o_error;
  int n_chk = 0;
  int n_pass = 0;
  logic [1:0] bt [7] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10};
  logic [3:0] en_t [7] = '{4'b1001, 4'b0001, 4'b1000, 4'b1001, 4'b0001, 4'b1000, 4'b1000};
  logic [1:0] bz_t [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
  always #5 i_clk = ~i_clk;
  yakirouter_sched #(.LEN_W(LEN_W)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_hdr_vld (i_hdr_vld),
    .i_hdr_dst (i_hdr_dst),
    .i_hdr_len (i_hdr_len),
    .i_beat_vld(i_beat_vld),
    .o_hdr_ack (o_hdr_ack),
    .o_in_busy (o_in_busy),
    .o_out_en  (o_out_en),
    .o_out_src (o_out_src),
    .o_error   (o_error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge i_clk);
    #1;
  endtask
  task automatic hdr(input int i, input logic [DST_W-1:0] d, input logic [LEN_W-1:0] l);
    i_hdr_vld[i] = 1'b1;
    i_hdr_dst[i] = d;
    i_hdr_len[i] = l;
  endtask
  initial begin
    #12;
    chk("reset_outs", {o_hdr_ack, o_in_busy, o_out_en, o_out_src}, 0);
    chk("reset_err", o_error, 0);
    #10 i_rstn = 1'b1;
    step;
    hdr(0, 2, 3);
    step;
    i_hdr_vld = '0;
    chk("s1_ack", o_hdr_ack, 2'b01);
    chk("s1_busy", o_in_busy, 2'b01);
    chk("s1_src2", o_out_src[2], 0);
    i_beat_vld = 2'b01;
    #1 chk("s1_en_b1", o_out_en, 4'b0100);
    step;
    chk("s1_ack_pulse", o_hdr_ack, 2'b00);
    chk("s1_en_b2", o_out_en, 4'b0100);
    step;
    chk("s1_en_b3", o_out_en, 4'b0100);
    chk("s1_busy_mid", o_in_busy, 2'b01);
    step;
    i_beat_vld = 2'b00;
    #1 chk("s1_busy_end", o_in_busy, 2'b00);
    chk("s1_en_end", o_out_en, 4'b0000);
    chk("s1_err", o_error, 0);
    hdr(0, 1, 2);
    hdr(1, 1, 2);
    step;
    i_hdr_vld[0] = 1'b0;
    chk("s2_ack0", o_hdr_ack, 2'b01);
    chk("s2_src_in0", o_out_src[1], 0);
    i_beat_vld = 2'b01;
    step;
    chk("s2_loser_noack", o_hdr_ack, 2'b00);
    chk("s2_en", o_out_en, 4'b0010);
    step;
    i_beat_vld = 2'b00;
    #1 chk("s2_idle_noack", o_hdr_ack, 2'b00);
    chk("s2_busy0_clr", o_in_busy, 2'b00);
    step;
    i_hdr_vld[1] = 1'b0;
    chk("s2_ack1", o_hdr_ack, 2'b10);
    chk("s2_src_in1", o_out_src[1], 1);
    i_beat_vld = 2'b10;
    #1 chk("s2_en1", o_out_en, 4'b0010);
    step;
    step;
    i_beat_vld = 2'b00;
    #1 chk("s2_busy1_clr", o_in_busy, 2'b00);
    hdr(0, 1, 1);
    step;
    i_hdr_vld = '0;
    chk("s2b_solo_ack", o_hdr_ack, 2'b01);
    i_beat_vld = 2'b01;
    step;
    i_beat_vld = 2'b00;
    hdr(0, 1, 1);
    hdr(1, 1, 1);
    step;
    i_hdr_vld[1] = 1'b0;
    chk("s2b_rr_ack1", o_hdr_ack, 2'b10);
    chk("s2b_rr_src", o_out_src[1], 1);
    i_beat_vld = 2'b10;
    step;
    i_beat_vld = 2'b00;
    step;
    i_hdr_vld = '0;
    chk("s2b_rr_ack0", o_hdr_ack, 2'b01);
    i_beat_vld = 2'b01;
    step;
    i_beat_vld = 2'b00;
    #1 chk("s2b_busy_end", o_in_busy, 2'b00);
    hdr(0, 0, 4);
    hdr(1, 3, 5);
    step;
    i_hdr_vld = '0;
    chk("s3_ack_both", o_hdr_ack, 2'b11);
    chk("s3_src", {o_out_src[3], o_out_src[0]}, 2'b10);
    for (int k = 0; k < 7; k++) begin
      i_beat_vld = bt[k];
      #1 chk($sformatf("s3_en_%0d", k), o_out_en, en_t[k]);
      step;
      chk($sformatf("s3_busy_%0d", k), o_in_busy, bz_t[k]);
    end
    i_beat_vld = 2'b00;
    #1 chk("s3_err", o_error, 0);
    hdr(0, 2, 0);
    step;
    i_hdr_vld = '0;
    chk("e0_ack", o_hdr_ack, 2'b01);
    chk("e0_err", o_error, 1);
    chk("e0_busy", o_in_busy, 2'b00);
    step;
    chk("e0_err_pulse", o_error, 0);
    hdr(1, 2, 1);
    step;
    i_hdr_vld = '0;
    chk("e0_idle_grant", o_hdr_ack, 2'b10);
    chk("e0_src2", o_out_src[2], 1);
    i_beat_vld = 2'b10;
    step;
    i_beat_vld = 2'b00;
    hdr(0, 3, 0);
    hdr(1, 3, 2);
    step;
    i_hdr_vld = '0;
    chk("e1_ack", o_hdr_ack, 2'b11);
    chk("e1_err", o_error, 1);
    chk("e1_busy", o_in_busy, 2'b10);
    chk("e1_src3", o_out_src[3], 1);
    i_beat_vld = 2'b10;
    step;
    step;
    i_beat_vld = 2'b00;
    #1 chk("e1_busy_end", o_in_busy, 2'b00);
    i_beat_vld = 2'b10;
    #1 chk("e2_en_none", o_out_en, 4'b0000);
    step;
    i_beat_vld = 2'b00;
    chk("e2_err", o_error, 1);
    step;
    chk("e2_err_pulse", o_error, 0);
    hdr(0, 1, 5);
    step;
    i_hdr_vld = '0;
    i_beat_vld = 2'b01;
    step;
    #2 i_rstn = 1'b0;
    #1 chk("r_async", {o_hdr_ack, o_in_busy, o_out_en, o_out_src}, 0);
    i_beat_vld = 2'b00;
    #2 i_rstn = 1'b1;
    step;
    chk("r_no_err", o_error, 0);
    chk("r_busy", o_in_busy, 2'b00);
    hdr(0, 1, 1);
    hdr(1, 1, 1);
    step;
    i_hdr_vld[0] = 1'b0;
    chk("r_ptr_reset", o_hdr_ack, 2'b01);
    i_beat_vld = 2'b01;
    step;
    i_beat_vld = 2'b00;
    step;
    i_hdr_vld = '0;
    chk("r_ack1", o_hdr_ack, 2'b10);
    i_beat_vld = 2'b10;
    step;
    i_beat_vld = 2'b00;
    #1 chk("r_busy_end", o_in_busy, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
